// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Debounces a raw pushbutton pin and turns it into a clean level plus
// single-cycle press / release / long-press events and a press counter.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a level
//                     change (2 .. 2^24-1)
//   LONG_CYCLES     : cycles a debounced press must persist to count as a
//                     long press (> DEBOUNCE_CYCLES, max 2^24-1)
//   ACTIVE_LOW      : 1 = pin reads 0 when pressed, 0 = pin reads 1 when pressed
//
// Ports
//   CLK         in   system clock, sole clock
//   RST_N       in   asynchronous active-low reset (deassertion pre-synchronized)
//   BTN         in   raw asynchronous pushbutton pin
//   BTN_LEVEL   out  debounced state, 1 = pressed regardless of ACTIVE_LOW
//   PRESS       out  one-cycle pulse on accepted press
//   RELEASE     out  one-cycle pulse on accepted release
//   LONG_PRESS  out  one-cycle pulse when a press has lasted LONG_CYCLES
//   PRESS_COUNT out  accepted presses, modulo 256
// -----------------------------------------------------------------------------
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 160000,
   parameter int unsigned LONG_CYCLES     = 16000000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       BTN,
   output logic       BTN_LEVEL,
   output logic       PRESS,
   output logic       RELEASE,
   output logic       LONG_PRESS,
   output logic [7:0] PRESS_COUNT
);

   localparam logic [23:0] DEB_LAST  = 24'(DEBOUNCE_CYCLES - 1);
   localparam logic [23:0] LONG_LAST = 24'(LONG_CYCLES - 1);

   // Raw pin value that corresponds to "released".
   localparam logic SYNC_IDLE = ACTIVE_LOW;

   localparam logic [1:0] RELEASED  = 2'd0;
   localparam logic [1:0] PRESSED   = 2'd1;
   localparam logic [1:0] LONG_HELD = 2'd2;

   logic        sync1;
   logic        sync2;
   logic        sample;
   logic        differ;
   logic        accept;
   logic        rise;
   logic        fall;
   logic [23:0] stab_cnt;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [23:0] hold_cnt;
   logic [23:0] hold_nxt;
   logic        press_nxt;
   logic        release_nxt;
   logic        long_nxt;

   // ---------------------------------------------------------------------------
   // Two-flop synchronizer; nothing looks at BTN or sync1 directly.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1 <= SYNC_IDLE;
         sync2 <= SYNC_IDLE;
      end else begin
         sync1 <= BTN;
         sync2 <= sync1;
      end
   end

   // Normalized sample: 1 = pressed.
   assign sample = ACTIVE_LOW ? ~sync2 : sync2;

   // ---------------------------------------------------------------------------
   // Stability counter and debounced level.
   // The level flips on the edge where the sample has already differed for
   // DEBOUNCE_CYCLES-1 counted cycles and still differs, giving a total
   // pin-to-level latency of 2 + DEBOUNCE_CYCLES for a clean edge.
   // ---------------------------------------------------------------------------
   assign differ = (sample != BTN_LEVEL);
   assign accept = differ && (stab_cnt == DEB_LAST);
   assign rise   = accept && sample;
   assign fall   = accept && !sample;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stab_cnt  <= '0;
         BTN_LEVEL <= 1'b0;
      end else if (!differ) begin
         stab_cnt  <= '0;
      end else if (accept) begin
         stab_cnt  <= '0;
         BTN_LEVEL <= sample;
      end else begin
         stab_cnt  <= stab_cnt + 24'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Press-tracking FSM.
   // Event pulses are computed from the same rise/fall terms that update
   // BTN_LEVEL, so PRESS/RELEASE land in the same cycle as the level edge.
   // A release always takes priority over the long-press qualification.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      hold_nxt    = hold_cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      case (state)
         RELEASED: begin
            hold_nxt = '0;
            if (rise) begin
               state_nxt = PRESSED;
               press_nxt = 1'b1;
            end
         end
         PRESSED: begin
            if (fall) begin
               state_nxt   = RELEASED;
               release_nxt = 1'b1;
               hold_nxt    = '0;
            end else if (hold_cnt == LONG_LAST) begin
               state_nxt = LONG_HELD;
               long_nxt  = 1'b1;
               hold_nxt  = hold_cnt + 24'd1;
            end else begin
               hold_nxt = hold_cnt + 24'd1;
            end
         end
         LONG_HELD: begin
            if (fall) begin
               state_nxt   = RELEASED;
               release_nxt = 1'b1;
               hold_nxt    = '0;
            end else if (hold_cnt != '1) begin
               // Saturates at all-ones; no further long-press events here.
               hold_nxt = hold_cnt + 24'd1;
            end
         end
         default: begin
            state_nxt = RELEASED;
            hold_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= RELEASED;
         hold_cnt   <= '0;
         PRESS      <= 1'b0;
         RELEASE    <= 1'b0;
         LONG_PRESS <= 1'b0;
      end else begin
         state      <= state_nxt;
         hold_cnt   <= hold_nxt;
         PRESS      <= press_nxt;
         RELEASE    <= release_nxt;
         LONG_PRESS <= long_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Press counter, wraps naturally at 256.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         PRESS_COUNT <= '0;
      end else if (press_nxt) begin
         PRESS_COUNT <= PRESS_COUNT + 8'd1;
      end
   end

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Instance a is ACTIVE_LOW=1, instance b is ACTIVE_LOW=0. Inputs change on
// the falling clock edge; outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

   logic       CLK;
   logic       RST_N;
   logic       btn_a;
   logic       btn_b;
   logic       level_a, press_a, release_a, long_a;
   logic [7:0] count_a;
   logic       level_b, press_b, release_b, long_b;
   logic [7:0] count_b;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Event bookkeeping, instance a
   int press_n_a   = 0;
   int rel_n_a     = 0;
   int long_n_a    = 0;
   int lvl_chg_a   = 0;
   int press_cyc_a = 0;
   int rel_cyc_a   = 0;
   int long_cyc_a  = 0;
   int lvl_rise_a  = 0;
   logic lvl_prev_a = 1'b0;
   // Event bookkeeping, instance b
   int press_n_b   = 0;
   int press_cyc_b = 0;
   int rel_cyc_b   = 0;
   int long_cyc_b  = 0;
   int excl_viol   = 0;

   button_debouncer #(
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES    (20),
      .ACTIVE_LOW     (1'b1)
   ) dut_a (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .BTN        (btn_a),
      .BTN_LEVEL  (level_a),
      .PRESS      (press_a),
      .RELEASE    (release_a),
      .LONG_PRESS (long_a),
      .PRESS_COUNT(count_a)
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES    (20),
      .ACTIVE_LOW     (1'b0)
   ) dut_b (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .BTN        (btn_b),
      .BTN_LEVEL  (level_b),
      .PRESS      (press_b),
      .RELEASE    (release_b),
      .LONG_PRESS (long_b),
      .PRESS_COUNT(count_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (press_a)   begin press_n_a++; press_cyc_a = cyc; end
      if (release_a) begin rel_n_a++;   rel_cyc_a   = cyc; end
      if (long_a)    begin long_n_a++;  long_cyc_a  = cyc; end
      if (level_a != lvl_prev_a) begin
         lvl_chg_a++;
         if (level_a) lvl_rise_a = cyc;
      end
      lvl_prev_a = level_a;
      if (press_b)   begin press_n_b++; press_cyc_b = cyc; end
      if (release_b) rel_cyc_b  = cyc;
      if (long_b)    long_cyc_b = cyc;
      if (int'(press_a) + int'(release_a) + int'(long_a) > 1) excl_viol++;
      if (int'(press_b) + int'(release_b) + int'(long_b) > 1) excl_viol++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   int t0, t1, p0, r0, l0, c0;

   initial begin
      RST_N = 1'b0;
      btn_a = 1'b1;
      btn_b = 1'b0;
      tick(3);
      check("rst_level", 32'(level_a), 0);
      check("rst_press", 32'(press_a), 0);
      check("rst_release", 32'(release_a), 0);
      check("rst_long", 32'(long_a), 0);
      check("rst_count", 32'(count_a), 0);
      RST_N = 1'b1;
      tick(3);

      // Clean press on both polarities, held long enough for a long press
      t0 = cyc;
      btn_a = 1'b0;
      btn_b = 1'b1;
      tick(30);
      t1 = cyc;
      btn_a = 1'b1;
      btn_b = 1'b0;
      tick(12);
      check("clean_press_n", 32'(press_n_a), 1);
      check("clean_press_lat", 32'(press_cyc_a - t0), 6);
      check("clean_level_lat", 32'(lvl_rise_a - t0), 6);
      check("clean_count", 32'(count_a), 1);
      check("clean_long_n", 32'(long_n_a), 1);
      check("clean_long_lat", 32'(long_cyc_a - press_cyc_a), 20);
      check("clean_rel_n", 32'(rel_n_a), 1);
      check("clean_rel_lat", 32'(rel_cyc_a - t1), 6);
      check("clean_level_end", 32'(level_a), 0);
      check("ahi_press_n", 32'(press_n_b), 1);
      check("ahi_press_lat", 32'(press_cyc_b - t0), 6);
      check("ahi_long_lat", 32'(long_cyc_b - press_cyc_b), 20);
      check("ahi_rel_lat", 32'(rel_cyc_b - t1), 6);
      check("ahi_count", 32'(count_b), 1);

      // Bounce: 3 low, 1 high, 3 low, then high
      p0 = press_n_a; r0 = rel_n_a; l0 = long_n_a; c0 = lvl_chg_a;
      btn_a = 1'b0; tick(3);
      btn_a = 1'b1; tick(1);
      btn_a = 1'b0; tick(3);
      btn_a = 1'b1; tick(12);
      check("bounce_press", 32'(press_n_a - p0), 0);
      check("bounce_level", 32'(lvl_chg_a - c0), 0);
      check("bounce_rel", 32'(rel_n_a - r0), 0);
      check("bounce_count", 32'(count_a), 1);

      // Short press
      p0 = press_n_a; r0 = rel_n_a; l0 = long_n_a;
      btn_a = 1'b0; tick(10);
      btn_a = 1'b1; tick(20);
      check("short_press", 32'(press_n_a - p0), 1);
      check("short_rel", 32'(rel_n_a - r0), 1);
      check("short_long", 32'(long_n_a - l0), 0);
      check("short_dur", 32'(rel_cyc_a - press_cyc_a), 10);
      check("short_count", 32'(count_a), 2);

      // Release on the exact cycle the hold would qualify: release wins
      r0 = rel_n_a; l0 = long_n_a;
      btn_a = 1'b0; tick(20);
      btn_a = 1'b1; tick(20);
      check("edge20_long", 32'(long_n_a - l0), 0);
      check("edge20_rel", 32'(rel_n_a - r0), 1);
      check("edge20_dur", 32'(rel_cyc_a - press_cyc_a), 20);

      // One cycle longer: long press fires, then release
      l0 = long_n_a;
      btn_a = 1'b0; tick(21);
      btn_a = 1'b1; tick(20);
      check("edge21_long", 32'(long_n_a - l0), 1);
      check("edge21_long_lat", 32'(long_cyc_a - press_cyc_a), 20);
      check("edge21_dur", 32'(rel_cyc_a - press_cyc_a), 21);
      check("edge21_count", 32'(count_a), 4);

      // Counter wrap from a fresh reset
      RST_N = 1'b0; tick(2);
      RST_N = 1'b1; tick(3);
      check("wrap_start", 32'(count_a), 0);
      p0 = press_n_a; r0 = rel_n_a;
      for (int i = 0; i < 255; i++) begin
         btn_a = 1'b0; tick(8);
         btn_a = 1'b1; tick(8);
      end
      check("wrap_255", 32'(count_a), 255);
      btn_a = 1'b0; tick(8);
      btn_a = 1'b1; tick(8);
      check("wrap_0", 32'(count_a), 0);
      check("wrap_press_n", 32'(press_n_a - p0), 256);
      check("wrap_rel_n", 32'(rel_n_a - r0), 256);

      // Reset while in the long-held state
      btn_a = 1'b0; tick(40);
      check("hold_level", 32'(level_a), 1);
      r0 = rel_n_a;
      RST_N = 1'b0;
      #1;
      check("mid_rst_level", 32'(level_a), 0);
      check("mid_rst_press", 32'(press_a), 0);
      check("mid_rst_release", 32'(release_a), 0);
      check("mid_rst_long", 32'(long_a), 0);
      check("mid_rst_count", 32'(count_a), 0);
      tick(2);
      RST_N = 1'b1;
      t0 = cyc;
      tick(10);
      check("mid_rst_no_rel", 32'(rel_n_a - r0), 0);
      check("mid_rst_repress", 32'(press_cyc_a - t0), 6);
      check("mid_rst_count1", 32'(count_a), 1);
      btn_a = 1'b1; tick(12);
      check("mid_rst_final_rel", 32'(rel_n_a - r0), 1);

      check("exclusive", 32'(excl_viol), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 160000, consecutive stable cycles required to accept a level change (10 ms at 16 MHz); legal range 2..2^24-1.
REQ-002 Parameter: LONG_CYCLES, 16000000, cycles a debounced press must persist to qualify as a long press (1 s at 16 MHz); SHALL exceed DEBOUNCE_CYCLES, max 2^24-1.
REQ-003 Parameter: ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (pull-up wiring), 0 = pin reads 1 when pressed.
REQ-004 Port: CLK  input  1  16 MHz system clock; sole clock.
REQ-005 Port: RST_N  input  1  reset; asynchronous assert, active-low.
REQ-006 Port: BTN  input  1  raw asynchronous pushbutton pin.
REQ-007 Port: BTN_LEVEL  output  1  debounced state, 1 = pressed, independent of ACTIVE_LOW.
REQ-008 Port: PRESS  output  1  one-cycle pulse on accepted press.
REQ-009 Port: RELEASE  output  1  one-cycle pulse on accepted release.
REQ-010 Port: LONG_PRESS  output  1  one-cycle pulse when a press reaches LONG_CYCLES.
REQ-011 Port: PRESS_COUNT  output  8  count of accepted presses, modulo 256.

Function
REQ-012 BTN SHALL pass through a two-flop synchronizer, then be normalized by ACTIVE_LOW to 1 = pressed; no logic SHALL use BTN before the second flop.
REQ-013 A 24-bit stability counter SHALL increment each cycle the synchronized sample differs from BTN_LEVEL and clear to 0 on any cycle it equals BTN_LEVEL.
REQ-014 When the stability counter is DEBOUNCE_CYCLES-1 and the sample still differs, BTN_LEVEL SHALL toggle on that edge and the counter SHALL clear; pin-to-BTN_LEVEL latency is exactly 2+DEBOUNCE_CYCLES cycles for a clean edge.
REQ-015 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on any output.
REQ-016 FSM states: RELEASED, PRESSED, LONG_HELD; reset state RELEASED.
REQ-017 RELEASED -> PRESSED on the edge BTN_LEVEL goes 1; PRESS SHALL be 1 for exactly that one cycle, registered concurrently with BTN_LEVEL.
REQ-018 PRESSED: a 24-bit hold counter SHALL start at 0 on entry and increment each cycle; on reaching LONG_CYCLES-1 the FSM SHALL go to LONG_HELD and LONG_PRESS SHALL pulse one cycle.
REQ-019 LONG_HELD SHALL issue no further LONG_PRESS pulses regardless of hold duration; the hold counter SHALL saturate, never wrap.
REQ-020 PRESSED or LONG_HELD -> RELEASED on the edge BTN_LEVEL goes 0; RELEASE SHALL pulse one cycle in the same cycle as BTN_LEVEL falling.
REQ-021 Release on the same cycle the hold counter would reach LONG_CYCLES-1: release wins, no LONG_PRESS pulse.
REQ-022 PRESS_COUNT SHALL increment by 1 on each PRESS pulse and wrap 255 -> 0 without other side effects.
REQ-023 PRESS, RELEASE, LONG_PRESS SHALL be mutually exclusive in any cycle.
REQ-024 All outputs SHALL be registered; no combinational path from BTN to any output.

Reset
REQ-025 RST_N low SHALL immediately force BTN_LEVEL=0, PRESS=0, RELEASE=0, LONG_PRESS=0, PRESS_COUNT=0, both counters=0, FSM=RELEASED, synchronizer flops to the normalized released value.
REQ-026 Reset asserted mid-press SHALL emit no RELEASE pulse; if the button is still held after RST_N deasserts, a fresh PRESS SHALL follow after 2+DEBOUNCE_CYCLES cycles.
REQ-027 RST_N deassertion is assumed synchronized externally; the block SHALL add no reset synchronizer.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1)
REQ-028 Clean press: BTN 1->0 held 30 cycles -> BTN_LEVEL rises and PRESS pulses exactly 6 cycles after the pin edge; PRESS_COUNT=1; LONG_PRESS pulses once 20 cycles after PRESS.
REQ-029 Bounce: BTN low 3 cycles, high 1, low 3, high -> no PRESS, BTN_LEVEL stays 0, PRESS_COUNT=0.
REQ-030 Short press: BTN low 10 cycles then high -> one PRESS, one RELEASE 10 cycles after PRESS, no LONG_PRESS.
REQ-031 Wrap: 256 clean presses -> PRESS_COUNT returns to 0, 256 PRESS and 256 RELEASE pulses counted.
REQ-032 Reset mid-hold: RST_N low 2 cycles while BTN held low in LONG_HELD -> outputs 0, no RELEASE; PRESS reappears 6 cycles after RST_N rises.
REQ-033 ACTIVE_LOW=0 build: BTN 0->1 held -> identical timing to REQ-028.
